vx_perf_memsys_reader: RTL and testbench



---
 rtl/vx_perf_memsys_pkg.sv | 35 +++
 rtl/vx_perf_memsys_reader_arb.sv | 45 ++++
 rtl/vx_perf_memsys_reader.sv | 148 ++++++++++++++
 tb/tb_vx_perf_memsys_reader.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/vx_perf_memsys_pkg.sv
// Shared constants for the memory-system perf counter reader: counter index map and FSM encoding.
// PERF_CTR_BITS falls back to 44 when the build does not supply it.
`ifndef PERF_CTR_BITS
`define PERF_CTR_BITS 44
`endif

package vx_perf_memsys_pkg;

  localparam int unsigned NUM_MEMSYS_CTRS = 15;
  localparam int unsigned CTR_IDX_BITS    = 4;
  localparam int unsigned ADDR_BITS       = 5;

  localparam logic [3:0] CTR_ICACHE_READS        = 4'd0;
  localparam logic [3:0] CTR_ICACHE_READ_MISSES  = 4'd1;
  localparam logic [3:0] CTR_DCACHE_READS        = 4'd2;
  localparam logic [3:0] CTR_DCACHE_WRITES       = 4'd3;
  localparam logic [3:0] CTR_DCACHE_READ_MISSES  = 4'd4;
  localparam logic [3:0] CTR_DCACHE_WRITE_MISSES = 4'd5;
  localparam logic [3:0] CTR_DCACHE_BANK_STALLS  = 4'd6;
  localparam logic [3:0] CTR_DCACHE_MSHR_STALLS  = 4'd7;
  localparam logic [3:0] CTR_SMEM_READS          = 4'd8;
  localparam logic [3:0] CTR_SMEM_WRITES         = 4'd9;
  localparam logic [3:0] CTR_SMEM_BANK_STALLS    = 4'd10;
  localparam logic [3:0] CTR_MEM_READS           = 4'd11;
  localparam logic [3:0] CTR_MEM_WRITES          = 4'd12;
  localparam logic [3:0] CTR_MEM_LATENCY         = 4'd13;
  localparam logic [3:0] CTR_SAME_ACCESS         = 4'd14;
  localparam logic [3:0] CTR_NONE                = 4'd15;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_READ = 2'd1;
  localparam state_t ST_RESP = 2'd2;

endpackage

// File: rtl/vx_perf_memsys_reader_arb.sv
// Round-robin arbiter: scans requests starting at r_ptr; pointer moves past the winner on i_ack.
module vx_perf_memsys_reader_arb #(
  parameter int unsigned NUM_REQS = 2,
  parameter int unsigned IDX_W    = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REQS-1:0] i_req,
  input  logic                i_ack,
  output logic                o_valid,
  output logic [IDX_W-1:0]    o_grant,
  output logic [NUM_REQS-1:0] o_grant_onehot
);

  logic [IDX_W-1:0] r_ptr;
  logic             w_valid;
  logic [IDX_W-1:0] w_grant;

  // Walk from the farthest offset down so the nearest requester to r_ptr wins last.
  always_comb begin
    w_valid = 1'b0;
    w_grant = '0;
    for (int i = NUM_REQS - 1; i >= 0; i--) begin
      int unsigned j;
      j = (32'(r_ptr) + 32'(i)) % NUM_REQS;
      if (i_req[j]) begin
        w_valid = 1'b1;
        w_grant = IDX_W'(j);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (i_ack && w_valid) begin
      r_ptr <= (32'(w_grant) == NUM_REQS - 1) ? '0 : w_grant + 1'b1;
    end
  end

  assign o_valid        = w_valid;
  assign o_grant        = w_grant;
  assign o_grant_onehot = w_valid ? (NUM_REQS'(1) << w_grant) : '0;

endmodule

// File: rtl/vx_perf_memsys_reader.sv
// Shared read-out of the memsys perf counter bundle as 32-bit halves with per-requester hold.
// Optional VX_PERF_MEMSYS_BASELINE_EN adds i_baseline_clr and baseline-relative reads.
module vx_perf_memsys_reader
  import vx_perf_memsys_pkg::*;
#(
  parameter int unsigned NUM_REQS   = 2,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CTR_BITS   = `PERF_CTR_BITS
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_MEMSYS_CTRS*CTR_BITS-1:0] i_perf_memsys,
  input  logic [NUM_REQS-1:0]               i_req_valid,
  input  logic [NUM_REQS*ADDR_BITS-1:0]     i_req_addr,
  output logic [NUM_REQS-1:0]               o_req_ready,
  output logic [NUM_REQS-1:0]               o_rsp_valid,
  output logic [NUM_REQS*DATA_WIDTH-1:0]    o_rsp_data,
  input  logic [NUM_REQS-1:0]               i_rsp_ready
`ifdef VX_PERF_MEMSYS_BASELINE_EN
  ,
  input  logic                              i_baseline_clr
`endif
);

  localparam int unsigned IDX_W = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

  state_t                r_state;
  logic [IDX_W-1:0]      r_grant;
  logic [ADDR_BITS-1:0]  r_addr;
  logic [63:0]           r_hold [NUM_REQS];
  logic [DATA_WIDTH-1:0] r_rsp_word;

  logic                  w_arb_valid;
  logic [IDX_W-1:0]      w_arb_grant;
  logic [NUM_REQS-1:0]   w_arb_onehot;
  logic                  w_arb_ack;
  logic [ADDR_BITS-1:0]  w_grant_addr;
  logic [3:0]            w_idx;
  logic                  w_hi;
  logic [CTR_BITS-1:0]   w_ctr_raw;
  logic [CTR_BITS-1:0]   w_ctr_base;
  logic [CTR_BITS-1:0]   w_ctr;
  logic [63:0]           w_val;
  logic [DATA_WIDTH-1:0] w_rsp_word;

`ifdef VX_PERF_MEMSYS_BASELINE_EN
  logic [CTR_BITS-1:0] r_baseline [NUM_MEMSYS_CTRS];
`endif

  assign w_arb_ack = (r_state == ST_IDLE) && w_arb_valid;

  vx_perf_memsys_reader_arb #(
    .NUM_REQS (NUM_REQS),
    .IDX_W    (IDX_W)
  ) u_arb (
    .clk            (clk),
    .reset          (reset),
    .i_req          (i_req_valid),
    .i_ack          (w_arb_ack),
    .o_valid        (w_arb_valid),
    .o_grant        (w_arb_grant),
    .o_grant_onehot (w_arb_onehot)
  );

  assign w_grant_addr = i_req_addr[int'(w_arb_grant)*ADDR_BITS +: ADDR_BITS];
  assign w_idx        = r_addr[ADDR_BITS-1:1];
  assign w_hi         = r_addr[0];

  always_comb begin
    w_ctr_raw  = '0;
    w_ctr_base = '0;
    for (int k = 0; k < int'(NUM_MEMSYS_CTRS); k++) begin
      if (w_idx == CTR_IDX_BITS'(k)) begin
        w_ctr_raw = i_perf_memsys[k*CTR_BITS +: CTR_BITS];
`ifdef VX_PERF_MEMSYS_BASELINE_EN
        w_ctr_base = r_baseline[k];
`endif
      end
    end
  end

  // Subtraction wraps at CTR_BITS, giving (counter - baseline) mod 2^CTR_BITS.
  assign w_ctr = w_ctr_raw - w_ctr_base;
  assign w_val = 64'(w_ctr);

  always_comb begin
    if (w_idx == CTR_NONE) begin
      w_rsp_word = '0;
    end else if (w_hi) begin
      w_rsp_word = r_hold[r_grant][63:32];
    end else begin
      w_rsp_word = w_val[31:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_grant    <= '0;
      r_addr     <= '0;
      r_rsp_word <= '0;
      for (int i = 0; i < int'(NUM_REQS); i++) r_hold[i] <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_arb_valid) begin
            r_grant <= w_arb_grant;
            r_addr  <= w_grant_addr;
            r_state <= ST_READ;
          end
        end
        ST_READ: begin
          r_rsp_word <= w_rsp_word;
          if (!w_hi && (w_idx != CTR_NONE)) r_hold[r_grant] <= w_val;
          r_state <= ST_RESP;
        end
        ST_RESP: begin
          if (i_rsp_ready[r_grant]) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef VX_PERF_MEMSYS_BASELINE_EN
  // A READ in the same cycle as the pulse still sees the old baseline.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < int'(NUM_MEMSYS_CTRS); k++) r_baseline[k] <= '0;
    end else if (i_baseline_clr) begin
      for (int k = 0; k < int'(NUM_MEMSYS_CTRS); k++) begin
        r_baseline[k] <= i_perf_memsys[k*CTR_BITS +: CTR_BITS];
      end
    end
  end
`endif

  assign o_req_ready = (r_state == ST_IDLE) ? w_arb_onehot : '0;
  assign o_rsp_valid = (r_state == ST_RESP) ? (NUM_REQS'(1) << r_grant) : '0;

  always_comb begin
    o_rsp_data = '0;
    for (int i = 0; i < int'(NUM_REQS); i++) begin
      if (32'(r_grant) == 32'(i)) o_rsp_data[i*DATA_WIDTH +: DATA_WIDTH] = r_rsp_word;
    end
  end

endmodule

// File: tb/tb_vx_perf_memsys_reader.sv
// Directed bench for vx_perf_memsys_reader with hand-computed expected words.
module tb_vx_perf_memsys_reader;
  import vx_perf_memsys_pkg::*;

  localparam int unsigned NR = 2;
  localparam int unsigned CB = 44;

  logic                        clk = 1'b0;
  logic                        reset;
  logic [NUM_MEMSYS_CTRS*CB-1:0] perf;
  logic [NR-1:0]               req_valid;
  logic [NR*5-1:0]             req_addr;
  logic [NR-1:0]               req_ready;
  logic [NR-1:0]               rsp_valid;
  logic [NR*32-1:0]            rsp_data;
  logic [NR-1:0]               rsp_ready;
`ifdef VX_PERF_MEMSYS_BASELINE_EN
  logic                        baseline_clr;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  vx_perf_memsys_reader #(
    .NUM_REQS   (NR),
    .DATA_WIDTH (32),
    .CTR_BITS   (CB)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .i_perf_memsys  (perf),
    .i_req_valid    (req_valid),
    .i_req_addr     (req_addr),
    .o_req_ready    (req_ready),
    .o_rsp_valid    (rsp_valid),
    .o_rsp_data     (rsp_data),
    .i_rsp_ready    (rsp_ready)
`ifdef VX_PERF_MEMSYS_BASELINE_EN
    ,
    .i_baseline_clr (baseline_clr)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ctr(input int idx, input logic [63:0] v);
    perf[idx*CB +: CB] = v[CB-1:0];
  endtask

  // Single-requester transaction: checks ready at T, nothing at T+1, response at T+2.
  task automatic txn(input int lane, input logic [4:0] addr, input logic [31:0] exp,
                     input string tag);
    int k;
    req_addr[lane*5 +: 5] = addr;
    req_valid[lane] = 1'b1;
    #1;
    k = 0;
    while (!req_ready[lane] && k < 20) begin
      step();
      k++;
    end
    check({tag, "_ready"}, 64'(req_ready[lane]), 64'd1);
    step();
    req_valid[lane] = 1'b0;
    #1;
    check({tag, "_read_cycle_valid"}, 64'(rsp_valid), 64'd0);
    step();
    check({tag, "_valid"}, 64'(rsp_valid), 64'(2'b01 << lane));
    check({tag, "_data"}, 64'(rsp_data[lane*32 +: 32]), 64'(exp));
    rsp_ready[lane] = 1'b1;
    step();
    rsp_ready[lane] = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rr_exp [NR];
    int g;

    reset     = 1'b1;
    perf      = '0;
    req_valid = '0;
    req_addr  = '0;
    rsp_ready = '0;
`ifdef VX_PERF_MEMSYS_BASELINE_EN
    baseline_clr = 1'b0;
`endif
    step();
    step();
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_data", 64'(rsp_data), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    reset = 1'b0;
    #1;

    set_ctr(CTR_DCACHE_READS, 64'h12_3456_789A);
    txn(0, {CTR_DCACHE_READS, 1'b0}, 32'h3456_789A, "lo_idx2");
    set_ctr(CTR_DCACHE_READS, 64'h99_0000_0000);
    txn(0, {CTR_DCACHE_READS, 1'b1}, 32'h0000_0012, "hi_held");

    // Round robin from pointer 0 with both lanes requesting continuously.
    do_reset();
    set_ctr(CTR_ICACHE_READS, 64'h5_1111_2222);
    set_ctr(CTR_MEM_READS, 64'hA_3333_4444);
    req_addr[0 +: 5] = {CTR_ICACHE_READS, 1'b0};
    req_addr[5 +: 5] = {CTR_MEM_READS, 1'b0};
    rr_exp[0] = 32'h1111_2222;
    rr_exp[1] = 32'h3333_4444;
    req_valid = 2'b11;
    #1;
    for (int t = 0; t < 4; t++) begin
      g = t % 2;
      check("rr_grant", 64'(req_ready), 64'(2'b01 << g));
      step();
      step();
      check("rr_valid", 64'(rsp_valid), 64'(2'b01 << g));
      check("rr_data", 64'(rsp_data[g*32 +: 32]), 64'(rr_exp[g]));
      rsp_ready = 2'b11;
      step();
      rsp_ready = 2'b00;
      #1;
    end
    req_valid = 2'b00;
    #1;

    txn(0, {CTR_ICACHE_READS, 1'b1}, 32'h0000_0005, "hold_lane0");
    txn(1, {CTR_MEM_READS, 1'b1}, 32'h0000_000A, "hold_lane1");

    txn(0, {CTR_NONE, 1'b0}, 32'h0, "idx15_lo");
    txn(0, {CTR_NONE, 1'b1}, 32'h0, "idx15_hi");
    txn(0, {CTR_ICACHE_READS, 1'b1}, 32'h0000_0005, "idx15_hold_kept");

    // Response back-pressure, then reset landing in RESP.
    set_ctr(CTR_DCACHE_WRITES, 64'h7_0000_00AB);
    req_addr[5 +: 5] = {CTR_DCACHE_WRITES, 1'b0};
    req_valid = 2'b10;
    #1;
    check("stall_grant", 64'(req_ready), 64'(2'b10));
    step();
    req_valid = 2'b01;
    req_addr[0 +: 5] = {CTR_ICACHE_READS, 1'b1};
    #1;
    check("stall_read_ready", 64'(req_ready), 64'd0);
    step();
    for (int c = 0; c < 5; c++) begin
      check("stall_valid", 64'(rsp_valid), 64'(2'b10));
      check("stall_data", 64'(rsp_data), 64'h0000_00AB_0000_0000);
      check("stall_ready", 64'(req_ready), 64'd0);
      step();
    end
    rsp_ready = 2'b10;
    #1;
    check("accept_cycle_ready", 64'(req_ready), 64'd0);
    step();
    rsp_ready = 2'b00;
    #1;
    check("after_accept_ready", 64'(req_ready), 64'(2'b01));
    step();
    req_valid = 2'b00;
    step();
    check("pre_rst_valid", 64'(rsp_valid), 64'(2'b01));
    check("pre_rst_data", 64'(rsp_data[31:0]), 64'h5);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_valid", 64'(rsp_valid), 64'd0);
    check("mid_rst_data", 64'(rsp_data), 64'd0);
    step();
    step();
    reset = 1'b0;
    #1;
    check("post_rst_ready", 64'(req_ready), 64'd0);
    txn(0, {CTR_ICACHE_READS, 1'b1}, 32'h0, "hi_after_rst");

`ifdef VX_PERF_MEMSYS_BASELINE_EN
    set_ctr(CTR_MEM_READS, 64'd100);
    baseline_clr = 1'b1;
    step();
    baseline_clr = 1'b0;
    set_ctr(CTR_MEM_READS, 64'd130);
    txn(0, {CTR_MEM_READS, 1'b0}, 32'd30, "base_delta");
    set_ctr(CTR_MEM_READS, 64'd10);
    baseline_clr = 1'b1;
    step();
    baseline_clr = 1'b0;
    set_ctr(CTR_MEM_READS, 64'd5);
    txn(1, {CTR_MEM_READS, 1'b0}, 32'hFFFF_FFFB, "base_wrap_lo");
    txn(1, {CTR_MEM_READS, 1'b1}, 32'h0000_0FFF, "base_wrap_hi");
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
